// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and hazard controller for the RISC-V pipeline. A DEPTH-entry
//   scoreboard follows every instruction from EX (entry 0) to writeback
//   (entry DEPTH-1). For each source operand of the instruction in decode the
//   youngest producing entry is selected as the forward source. A load that is
//   still too young to forward raises a load-use stall. Bubbles are inserted
//   on stall, redirect or an empty decode slot. Saturating counters record
//   stall cycles and accepted redirects.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   inst, inst_valid  instruction in decode and its valid flag
//   stall_in          external freeze: scoreboard holds, redirect ignored
//   redirect          taken branch/jump resolved in EX this cycle
//   fwd_rs1, fwd_rs2  0 = register file, k = forward from entry k-1
//   hazard_stall      hold PC and decode register
//   insert_bubble     entry 0 receives a bubble at the next edge
//   wb_regwren, wb_rd register-file write enable / address from entry DEPTH-1
//   stall_cnt         saturating count of hazard_stall cycles
//   flush_cnt         saturating count of accepted redirects
module fwd_hazard_ctrl #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             stall_in,
  input  logic             redirect,
  output logic [FW-1:0]    fwd_rs1,
  output logic [FW-1:0]    fwd_rs2,
  output logic             hazard_stall,
  output logic             insert_bubble,
  output logic             wb_regwren,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] OP_LOAD   = 5'd0;
  localparam logic [4:0] OP_I      = 5'd4;
  localparam logic [4:0] OP_AUIPC  = 5'd5;
  localparam logic [4:0] OP_STORE  = 5'd8;
  localparam logic [4:0] OP_R      = 5'd12;
  localparam logic [4:0] OP_LUI    = 5'd13;
  localparam logic [4:0] OP_CSRW   = 5'd16;
  localparam logic [4:0] OP_CSRWI  = 5'd17;
  localparam logic [4:0] OP_BRANCH = 5'd24;
  localparam logic [4:0] OP_JALR   = 5'd25;
  localparam logic [4:0] OP_JAL    = 5'd27;

  // Scoreboard state
  logic [DEPTH-1:0] valid_reg, valid_next;
  logic [DEPTH-1:0] wr_reg, wr_next;
  logic [DEPTH-1:0] load_reg, load_next;
  logic [4:0]       rd_reg  [DEPTH];
  logic [4:0]       rd_next [DEPTH];

  // Decode classification
  logic [4:0] opcode, dec_rd, dec_rs1_idx, dec_rs2_idx;
  logic       dec_wr, dec_rs1, dec_rs2, dec_load;
  logic       unused_bits;

  assign opcode      = inst[6:2];
  assign dec_rd      = inst[11:7];
  assign dec_rs1_idx = inst[19:15];
  assign dec_rs2_idx = inst[24:20];
  assign dec_load    = (opcode == OP_LOAD);
  assign unused_bits = ^{inst[31:25], inst[14:12], inst[1:0]};

  always_comb begin
    dec_wr  = 1'b0;
    dec_rs1 = 1'b0;
    dec_rs2 = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR, OP_I, OP_CSRW: begin
        dec_wr  = 1'b1;
        dec_rs1 = 1'b1;
      end
      OP_R: begin
        dec_wr  = 1'b1;
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
      end
      OP_JAL, OP_AUIPC, OP_LUI, OP_CSRWI: dec_wr = 1'b1;
      OP_STORE, OP_BRANCH: begin
        dec_rs1 = 1'b1;
        dec_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-entry operand match. wr_reg already excludes rd=x0, so x0 never matches.
  logic [DEPTH-1:0] match1, match2;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match1[gi] = valid_reg[gi] & wr_reg[gi] & (rd_reg[gi] == dec_rs1_idx)
                        & dec_rs1 & inst_valid;
      assign match2[gi] = valid_reg[gi] & wr_reg[gi] & (rd_reg[gi] == dec_rs2_idx)
                        & dec_rs2 & inst_valid;
    end
  endgenerate

  // Walk from oldest to youngest so the youngest match overwrites; only the
  // youngest match decides whether the value is forwardable yet.
  logic haz1, haz2;
  always_comb begin
    fwd_rs1 = '0;
    fwd_rs2 = '0;
    haz1    = 1'b0;
    haz2    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match1[i]) begin
        fwd_rs1 = FW'(i + 1);
        haz1    = load_reg[i] && (i < LOAD_LAT);
      end
      if (match2[i]) begin
        fwd_rs2 = FW'(i + 1);
        haz2    = load_reg[i] && (i < LOAD_LAT);
      end
    end
  end

  // Redirect outranks load-use: the decode instruction is killed anyway.
  assign hazard_stall  = (haz1 | haz2) & ~redirect & ~stall_in;
  assign insert_bubble = (hazard_stall | redirect | ~inst_valid) & ~stall_in;

  assign wb_regwren = valid_reg[DEPTH-1] & wr_reg[DEPTH-1];
  assign wb_rd      = rd_reg[DEPTH-1];

  // Next scoreboard contents when the pipe advances
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign valid_next[0] = ~insert_bubble;
        assign wr_next[0]    = ~insert_bubble & dec_wr & (dec_rd != 5'd0);
        assign load_next[0]  = ~insert_bubble & dec_load;
        assign rd_next[0]    = insert_bubble ? 5'd0 : dec_rd;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign wr_next[gi]    = wr_reg[gi-1];
        assign load_next[gi]  = load_reg[gi-1];
        assign rd_next[gi]    = rd_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      wr_reg    <= '0;
      load_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) rd_reg[i] <= 5'd0;
    end else if (!stall_in) begin
      valid_reg <= valid_next;
      wr_reg    <= wr_next;
      load_reg  <= load_next;
      rd_reg    <= rd_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && !stall_in && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl. Three instances with different
// DEPTH / LOAD_LAT / CNT_W share one stimulus stream; a behavioural model per
// instance (a plain list of in-flight destinations) predicts every cycle's
// outputs into a scoreboard queue that a separate negedge monitor drains.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid, stall_in, redirect;

  always #5 clk = ~clk;

  // instance configurations
  localparam int P_D  [3] = '{2, 4, 3};
  localparam int P_L  [3] = '{1, 2, 0};
  localparam int P_CW [3] = '{16, 4, 16};

  logic [1:0]  f1_0, f2_0, f1_2, f2_2;
  logic [2:0]  f1_1, f2_1;
  logic [15:0] sc_0, fc_0, sc_2, fc_2;
  logic [3:0]  sc_1, fc_1;
  logic        hs [3];
  logic        ib [3];
  logic        wbw [3];
  logic [4:0]  wbrd [3];

  fwd_hazard_ctrl #(.DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .stall_in(stall_in), .redirect(redirect), .fwd_rs1(f1_0), .fwd_rs2(f2_0),
    .hazard_stall(hs[0]), .insert_bubble(ib[0]), .wb_regwren(wbw[0]),
    .wb_rd(wbrd[0]), .stall_cnt(sc_0), .flush_cnt(fc_0));

  fwd_hazard_ctrl #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .stall_in(stall_in), .redirect(redirect), .fwd_rs1(f1_1), .fwd_rs2(f2_1),
    .hazard_stall(hs[1]), .insert_bubble(ib[1]), .wb_regwren(wbw[1]),
    .wb_rd(wbrd[1]), .stall_cnt(sc_1), .flush_cnt(fc_1));

  fwd_hazard_ctrl #(.DEPTH(3), .LOAD_LAT(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .stall_in(stall_in), .redirect(redirect), .fwd_rs1(f1_2), .fwd_rs2(f2_2),
    .hazard_stall(hs[2]), .insert_bubble(ib[2]), .wb_regwren(wbw[2]),
    .wb_rd(wbrd[2]), .stall_cnt(sc_2), .flush_cnt(fc_2));

  int a_f1 [3];
  int a_f2 [3];
  int a_sc [3];
  int a_fc [3];
  always_comb begin
    a_f1[0] = int'(f1_0); a_f1[1] = int'(f1_1); a_f1[2] = int'(f1_2);
    a_f2[0] = int'(f2_0); a_f2[1] = int'(f2_1); a_f2[2] = int'(f2_2);
    a_sc[0] = int'(sc_0); a_sc[1] = int'(sc_1); a_sc[2] = int'(sc_2);
    a_fc[0] = int'(fc_0); a_fc[1] = int'(fc_1); a_fc[2] = int'(fc_2);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int n, cyc;
    int f1, f2, hs, ib, wbw, wbrd, sc, fc;
    bit chk_rd;
  } exp_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic chk(input int n, input int c, input string nm, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL u%0d cycle %0d %s: got %0d expected %0d", n, c, nm, got, exp);
    end
  endtask

  exp_t me;
  always @(negedge clk) begin
    while (sbq.size() != 0) begin
      me = sbq.pop_front();
      chk(me.n, me.cyc, "fwd_rs1", a_f1[me.n], me.f1);
      chk(me.n, me.cyc, "fwd_rs2", a_f2[me.n], me.f2);
      chk(me.n, me.cyc, "hazard_stall", int'(hs[me.n]), me.hs);
      chk(me.n, me.cyc, "insert_bubble", int'(ib[me.n]), me.ib);
      chk(me.n, me.cyc, "wb_regwren", int'(wbw[me.n]), me.wbw);
      if (me.chk_rd) chk(me.n, me.cyc, "wb_rd", int'(wbrd[me.n]), me.wbrd);
      chk(me.n, me.cyc, "stall_cnt", a_sc[me.n], me.sc);
      chk(me.n, me.cyc, "flush_cnt", a_fc[me.n], me.fc);
    end
  end

  // ---------------- reference model ----------------
  // Each in-flight slot holds: occupied, destination register (0 = none), is-load.
  bit m_valid [3][4];
  int m_dest  [3][4];
  bit m_load  [3][4];
  int m_sc [3];
  int m_fc [3];
  bit m_hs [3];
  bit m_ib [3];

  function automatic bit op_writes(input int o);
    return o inside {0, 25, 27, 12, 4, 5, 13, 16, 17};
  endfunction
  function automatic bit op_reads1(input int o);
    return o inside {0, 25, 12, 4, 16, 8, 24};
  endfunction
  function automatic bit op_reads2(input int o);
    return o inside {12, 8, 24};
  endfunction

  task automatic model_clear(input int n);
    for (int i = 0; i < 4; i++) begin
      m_valid[n][i] = 0; m_dest[n][i] = 0; m_load[n][i] = 0;
    end
    m_sc[n] = 0;
    m_fc[n] = 0;
  endtask

  // Youngest in-flight producer of register s (s=0 means "no operand read").
  task automatic youngest(input int n, input int s, output int fwd, output bit haz);
    fwd = 0;
    haz = 0;
    if (s != 0) begin
      for (int i = 0; i < P_D[n]; i++) begin
        if (m_valid[n][i] && m_dest[n][i] == s) begin
          fwd = i + 1;
          haz = m_load[n][i] && (i < P_L[n]);
          break;
        end
      end
    end
  endtask

  task automatic model_eval(input int n, output exp_t e);
    int  o, s1, s2, d;
    bit  h1, h2;
    o  = int'(inst[6:2]);
    s1 = (inst_valid && op_reads1(o)) ? int'(inst[19:15]) : 0;
    s2 = (inst_valid && op_reads2(o)) ? int'(inst[24:20]) : 0;
    d  = P_D[n];
    e.n   = n;
    e.cyc = cyc;
    youngest(n, s1, e.f1, h1);
    youngest(n, s2, e.f2, h2);
    m_hs[n] = (h1 || h2) && !redirect && !stall_in;
    m_ib[n] = (m_hs[n] || redirect || !inst_valid) && !stall_in;
    e.hs     = int'(m_hs[n]);
    e.ib     = int'(m_ib[n]);
    e.wbw    = (m_valid[n][d-1] && m_dest[n][d-1] != 0) ? 1 : 0;
    e.wbrd   = m_dest[n][d-1];
    e.chk_rd = (e.wbw == 1) || rst;
    e.sc     = m_sc[n];
    e.fc     = m_fc[n];
  endtask

  task automatic model_step(input int n);
    int o, mx;
    o  = int'(inst[6:2]);
    mx = (1 << P_CW[n]) - 1;
    if (m_hs[n] && m_sc[n] < mx) m_sc[n]++;
    if (redirect && !stall_in && m_fc[n] < mx) m_fc[n]++;
    if (!stall_in) begin
      for (int i = P_D[n] - 1; i > 0; i--) begin
        m_valid[n][i] = m_valid[n][i-1];
        m_dest[n][i]  = m_dest[n][i-1];
        m_load[n][i]  = m_load[n][i-1];
      end
      m_valid[n][0] = !m_ib[n];
      m_dest[n][0]  = (!m_ib[n] && op_writes(o)) ? int'(inst[11:7]) : 0;
      m_load[n][0]  = !m_ib[n] && (o == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input int opc, input int rd, input int r1, input int r2);
    logic [31:0] x;
    x        = $urandom();
    x[1:0]   = 2'b11;
    x[6:2]   = 5'(opc);
    x[11:7]  = 5'(rd);
    x[19:15] = 5'(r1);
    x[24:20] = 5'(r2);
    return x;
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic cycle(input logic [31:0] i, input bit iv, input bit st,
                       input bit rd_, input bit rs);
    exp_t e;
    inst = i; inst_valid = iv; stall_in = st; redirect = rd_; rst = rs;
    for (int n = 0; n < 3; n++) begin
      if (rs) model_clear(n);
      model_eval(n, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rs) for (int n = 0; n < 3; n++) model_step(n);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) cycle(32'h0, 0, 0, 0, 0);
  endtask

  localparam int OPS [12] = '{0, 25, 27, 12, 4, 5, 13, 16, 17, 8, 24, 3};

  initial begin
    rst = 1'b1; inst = '0; inst_valid = 0; stall_in = 0; redirect = 0;
    for (int n = 0; n < 3; n++) model_clear(n);
    repeat (2) @(posedge clk);
    #1;
    cycle(32'h0, 0, 0, 0, 1);
    cycle(mk(12, 5, 1, 2), 1, 0, 0, 1);
    cycle(mk(12, 5, 1, 2), 1, 0, 0, 0);     // reset just released, empty pipe
    // back-to-back dependency: add x5 / sub x6,x5 / use x5 again
    cycle(mk(12, 6, 5, 3), 1, 0, 0, 0);
    cycle(mk(12, 7, 5, 0), 1, 0, 0, 0);
    idle(5);
    // load-use: lw x7 then add x8,x7,x7 held in decode
    cycle(mk(0, 7, 1, 0), 1, 0, 0, 0);
    repeat (4) cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
    idle(5);
    // youngest wins, then x0 producer/consumer
    cycle(mk(4, 9, 1, 0), 1, 0, 0, 0);
    cycle(mk(4, 9, 2, 0), 1, 0, 0, 0);
    cycle(mk(12, 10, 9, 0), 1, 0, 0, 0);
    cycle(mk(0, 0, 1, 0), 1, 0, 0, 0);
    cycle(mk(12, 11, 0, 0), 1, 0, 0, 0);
    idle(5);
    // redirect during load-use
    cycle(mk(0, 7, 1, 0), 1, 0, 0, 0);
    cycle(mk(12, 8, 7, 7), 1, 0, 1, 0);
    cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
    idle(5);
    // freeze for 3 cycles with redirect asserted, then release
    cycle(mk(0, 7, 1, 0), 1, 0, 0, 0);
    repeat (3) cycle(mk(12, 8, 7, 7), 1, 1, 1, 0);
    repeat (3) cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
    idle(5);
    // asynchronous reset in the middle of a load-use stall
    cycle(mk(0, 7, 1, 0), 1, 0, 0, 0);
    cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
    cycle(mk(12, 8, 7, 7), 1, 0, 0, 1);
    cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
    idle(5);
    // drive both counters of the narrow instance into saturation
    for (int k = 0; k < 20; k++) begin
      cycle(mk(0, 7, 1, 0), 1, 0, 0, 0);
      repeat (3) cycle(mk(12, 8, 7, 7), 1, 0, 0, 0);
      cycle(mk(4, 3, 3, 0), 1, 0, 1, 0);
    end
    // randomized traffic over a small register pool to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      int o;
      o = OPS[$urandom_range(0, 11)];
      cycle(mk(o, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end
    // every pushed expectation must have been consumed by the monitor
    repeat (3) @(posedge clk);
    n_assert++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the RISC-V core pipeline. It tracks every in-flight instruction between decode and register-file writeback in a DEPTH-entry scoreboard and selects, per source operand, the youngest producing stage to forward from. It stalls decode on load-use hazards, inserts bubbles on stall or redirect, and keeps saturating stall and flush counters. It sits beside the datapath and replaces fixed two-stage forwarding with a depth- and latency-configurable unit.

## Interface
- DEPTH, 2: in-flight stages after decode; entry 0 = EX, entry DEPTH-1 = writeback. Legal range 1..4.
- LOAD_LAT, 1: load data is forwardable from entry i only when i >= LOAD_LAT. Legal range 0..DEPTH-1.
- CNT_W, 16: width of the performance counters.
- FW = $clog2(DEPTH+1): width of the forward selects.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction in decode.
- inst_valid  in  1  decode holds a real instruction.
- stall_in  in  1  external freeze (e.g. memory busy).
- redirect  in  1  taken branch/jump resolved in EX this cycle.
- fwd_rs1  out  FW  0 = register file; k = forward from entry k-1.
- fwd_rs2  out  FW  same encoding, for rs2.
- hazard_stall  out  1  hold PC and decode register.
- insert_bubble  out  1  entry 0 receives a bubble at the next edge.
- wb_regwren  out  1  entry DEPTH-1 is valid, writes rd, and rd != 0.
- wb_rd  out  5  rd of entry DEPTH-1.
- stall_cnt  out  CNT_W  cycles with hazard_stall=1.
- flush_cnt  out  CNT_W  accepted redirects.

## Operation
- Decode classification uses opcode = inst[6:2]:
  - Writes rd: LOAD 0, JALR 25, JAL 27, R 12, I 4, AUIPC 5, LUI 13, CSRW 16, CSRWI 17.
  - Reads rs1: every opcode except LUI, AUIPC, JAL, CSRWI.
  - Reads rs2: R, STORE 8, BRANCH 24 only.
  - Unlisted opcodes write and read nothing.
- Scoreboard entry fields: valid, wr (writes rd and rd != 0), rd[4:0], is_load.
- Register x0 never matches and never forwards or stalls.
- Operand match: entry valid, entry wr=1, entry rd equals rs1/rs2, and the decode instruction reads that operand with inst_valid=1.
- Forwarding:
  - fwd_rsN = k, where k-1 is the lowest-index (youngest) matching entry; 0 if no entry matches.
  - If that youngest match is a load with index < LOAD_LAT, forwarding is impossible and the load-use hazard is raised. Older matches are ignored.
- Outputs:
  - hazard_stall = load-use hazard & ~redirect & ~stall_in.
  - insert_bubble = (hazard_stall | redirect | ~inst_valid) & ~stall_in.
- Shift, when stall_in=0:
  - entry[k] <= entry[k-1].
  - entry[0] <= decode info, or invalid if insert_bubble.
  - entry[DEPTH-1] retires.
- When stall_in=1, all entries hold and redirect is ignored; EX re-asserts redirect after the freeze.
- Simultaneous redirect and load-use: redirect wins. The decode instruction is killed (bubble) and hazard_stall=0.
- Counters saturate at all-ones. stall_cnt increments on hazard_stall; flush_cnt increments on redirect & ~stall_in.

## Timing
- Reset (asynchronous): all entries invalid; stall_cnt=flush_cnt=0; wb_regwren=0, wb_rd=0.
- With entries invalid, fwd_rs1/rs2, hazard_stall and redirect-free insert_bubble (given inst_valid=1) are 0.
- All outputs except the counters are combinational from inst, the control inputs and the registered entries, with zero latency. Counters update at the edge.
- The register file writes wb_rd at the end of the cycle in which wb_regwren=1. The following cycle reads the new value from the register file.
- Default DEPTH=2, LOAD_LAT=1: a load immediately followed by a dependent instruction gives exactly 1 stall cycle, then fwd=2.
- LOAD_LAT=0: no load-use stall ever occurs.
- rst mid-stall discards all entries. hazard_stall drops in the same cycle the reset asserts.

## Test plan
- Back-to-back dependency: add x5,x1,x2 then sub x6,x5,x3 → cycle 2 fwd_rs1=1; one cycle later the same rd is seen as fwd=2; hazard_stall=0.
- Load-use (DEPTH=2, LOAD_LAT=1): lw x7,0(x1) then add x8,x7,x7 → hazard_stall=1 for 1 cycle, stall_cnt=1; next cycle fwd_rs1=fwd_rs2=2.
- Youngest wins: addi x9 twice in succession, then use of x9 → fwd_rs1=1, not 2. Also: rd=x0 producer followed by a read of x0 → fwd=0 and no stall.
- Redirect during load-use: load in entry 0, dependent instruction in decode, redirect=1 → hazard_stall=0, insert_bubble=1, flush_cnt=1, entry 0 becomes invalid.
- stall_in freeze: stall_in=1 for 3 cycles mid-sequence, plus redirect → entries and fwd unchanged, counters unchanged. After release, sequencing is identical to the unfrozen case.
- Parametric: DEPTH=4, LOAD_LAT=2 → load-use gives 2 stall cycles then fwd=3. Counters with CNT_W=4 saturate at 15. Asynchronous rst mid-stream clears all within the same cycle.
